// File: rtl/spark80_mem_responder.sv
// spark80_mem_responder
// Memory-side responder for the Spark80 CPU data bus. Accepts four-phase
// req_rdwr requests, performs 8/16-bit reads and writes on a word-organised
// RAM with little-endian byte lanes, and answers with data_ready.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous, active-high reset
//   req_rdwr       in   four-phase request level
//   addr_in        in   byte address [ADDR_WIDTH-1:0]
//   data_acc_sz    in   0 = 8-bit, 1 = 16-bit
//   data_inout_we  in   1 = write, 0 = read
//   write_data_in  in   write data (8-bit writes use [7:0])
//   read_data_out  out  registered read data (8-bit reads zero-extended)
//   data_ready     out  access complete
//   bus_err        out  out-of-range access (bounds-check builds only)
//
// Optional feature macro: SPARK80_MEM_RESP_BOUNDS_CHECK_EN
//   defined   : word index >= DEPTH_WORDS suppresses writes, reads 16'hFFFF,
//               bus_err high during DONE
//   undefined : word index wraps modulo DEPTH_WORDS, bus_err tied low
module spark80_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned DEPTH_WORDS = 2 ** (ADDR_WIDTH - 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_rdwr,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  data_acc_sz,
    input  logic                  data_inout_we,
    input  logic [15:0]           write_data_in,
    output logic [15:0]           read_data_out,
    output logic                  data_ready,
    output logic                  bus_err
);

    localparam int unsigned WORD_AW = ADDR_WIDTH - 1;
    localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);
    localparam bit NO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  size_q, size_d;
    logic                  we_q, we_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [15:0]           read_data_q, read_data_d;
    logic                  data_ready_q, data_ready_d;

    logic [ADDR_WIDTH-1:0] acc_addr_c;
    logic                  acc_size_c;
    logic                  acc_we_c;
    logic [15:0]           acc_wdata_c;
    logic [WORD_AW-1:0]    word_c;
    logic [IDX_W-1:0]      idx_c;
    logic                  oob_c;
    logic                  do_access_c;
    logic                  mem_we_c;
    logic [1:0]            lane_we_c;
    logic [15:0]           mem_wdata_c;
    logic [15:0]           mem_rd_c;
    logic [15:0]           rd_val_c;

    logic [15:0] mem [DEPTH_WORDS];

    // With no wait states the access happens on the accepting edge, so the
    // live inputs are used; otherwise the captured request is used.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_addr_c  = addr_in;
            acc_size_c  = data_acc_sz;
            acc_we_c    = data_inout_we;
            acc_wdata_c = write_data_in;
        end else begin
            acc_addr_c  = addr_q;
            acc_size_c  = size_q;
            acc_we_c    = we_q;
            acc_wdata_c = wdata_q;
        end
    end

    assign word_c = acc_addr_c[ADDR_WIDTH-1:1];

`ifdef SPARK80_MEM_RESP_BOUNDS_CHECK_EN
    assign oob_c = (32'(word_c) >= 32'(DEPTH_WORDS));
    assign idx_c = IDX_W'(word_c);
`else
    assign oob_c = 1'b0;
    assign idx_c = IDX_W'(32'(word_c) % 32'(DEPTH_WORDS));
`endif

    // Byte-lane decode: 16-bit hits both lanes, 8-bit hits the lane chosen by addr[0].
    always_comb begin
        if (acc_size_c) begin
            lane_we_c   = 2'b11;
            mem_wdata_c = acc_wdata_c;
        end else begin
            lane_we_c   = acc_addr_c[0] ? 2'b10 : 2'b01;
            mem_wdata_c = {acc_wdata_c[7:0], acc_wdata_c[7:0]};
        end
    end

    assign mem_rd_c = mem[idx_c];

    always_comb begin
        if (oob_c) begin
            rd_val_c = 16'hFFFF;
        end else if (acc_size_c) begin
            rd_val_c = mem_rd_c;
        end else begin
            rd_val_c = {8'h00, acc_addr_c[0] ? mem_rd_c[15:8] : mem_rd_c[7:0]};
        end
    end

    // Reset gates the write so an access cut off by reset never lands.
    assign mem_we_c = do_access_c & acc_we_c & ~oob_c & ~reset;

    // RAM contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            if (lane_we_c[0]) mem[idx_c][7:0]  <= mem_wdata_c[7:0];
            if (lane_we_c[1]) mem[idx_c][15:8] <= mem_wdata_c[15:8];
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        size_d       = size_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        do_access_c  = 1'b0;
        // data_ready trails the DONE state by one register stage.
        data_ready_d = (state_q == ST_DONE);

        unique case (state_q)
            ST_IDLE: begin
                if (req_rdwr) begin
                    addr_d  = addr_in;
                    size_d  = data_acc_sz;
                    we_d    = data_inout_we;
                    wdata_d = write_data_in;
                    cnt_d   = WAIT_LOAD;
                    if (NO_WAIT) begin
                        do_access_c = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    do_access_c = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!req_rdwr) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        read_data_d = read_data_q;
        if (do_access_c && !acc_we_c) begin
            read_data_d = rd_val_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            size_q       <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= 16'h0000;
            read_data_q  <= 16'h0000;
            data_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            read_data_q  <= read_data_d;
            data_ready_q <= data_ready_d;
        end
    end

    assign read_data_out = read_data_q;
    assign data_ready    = data_ready_q;

`ifdef SPARK80_MEM_RESP_BOUNDS_CHECK_EN
    logic bus_err_q, bus_err_d;

    // In DONE the access mux selects the captured address, so oob_c applies to it.
    always_comb begin
        bus_err_d = (state_q == ST_DONE) & oob_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_spark80_mem_responder.sv
// Directed bench for spark80_mem_responder: a zero-wait instance with 256
// words and a three-wait-state instance with the full address space.
module tb_spark80_mem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        req0, sz0, we0;
    logic [15:0] addr0, wd0, rd0;
    logic        rdy0, err0;

    logic        req3, sz3, we3;
    logic [15:0] addr3, wd3, rd3;
    logic        rdy3, err3;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] rdata;
    logic        berr;

    always #5 clk = ~clk;

    spark80_mem_responder #(
        .ADDR_WIDTH (16),
        .WAIT_STATES(0),
        .DEPTH_WORDS(256)
    ) u_dut0 (
        .clk          (clk),
        .reset        (reset),
        .req_rdwr     (req0),
        .addr_in      (addr0),
        .data_acc_sz  (sz0),
        .data_inout_we(we0),
        .write_data_in(wd0),
        .read_data_out(rd0),
        .data_ready   (rdy0),
        .bus_err      (err0)
    );

    spark80_mem_responder #(
        .ADDR_WIDTH (16),
        .WAIT_STATES(3)
    ) u_dut3 (
        .clk          (clk),
        .reset        (reset),
        .req_rdwr     (req3),
        .addr_in      (addr3),
        .data_acc_sz  (sz3),
        .data_inout_we(we3),
        .write_data_in(wd3),
        .read_data_out(rd3),
        .data_ready   (rdy3),
        .bus_err      (err3)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic req, input logic we, input logic sz,
                         input logic [15:0] addr, input logic [15:0] wd);
        if (sel) begin
            req3 = req; we3 = we; sz3 = sz; addr3 = addr; wd3 = wd;
        end else begin
            req0 = req; we0 = we; sz0 = sz; addr0 = addr; wd0 = wd;
        end
    endtask

    function automatic logic get_rdy(input bit sel);
        return sel ? rdy3 : rdy0;
    endfunction

    function automatic logic [15:0] get_rd(input bit sel);
        return sel ? rd3 : rd0;
    endfunction

    function automatic logic get_err(input bit sel);
        return sel ? err3 : err0;
    endfunction

    // One four-phase transaction: checks latency, optional hold in DONE, and release timing.
    task automatic bus_access(input string tag, input bit sel, input logic we, input logic sz,
                              input logic [15:0] addr, input logic [15:0] wd,
                              input int exp_lat, input int hold, input bit scramble,
                              output logic [15:0] rdata_o, output logic berr_o);
        int n;
        bit seen;
        @(negedge clk);
        drive(sel, 1'b1, we, sz, addr, wd);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 64) begin
            @(negedge clk);
            if (get_rdy(sel)) begin
                seen = 1'b1;
            end else begin
                n++;
                if (scramble) begin
                    drive(sel, 1'b1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
                end
            end
        end
        check({tag, ".latency"}, 16'(n), 16'(exp_lat));
        rdata_o = get_rd(sel);
        berr_o  = get_err(sel);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            drive(sel, 1'b1, we, sz, addr ^ 16'h0012, wd ^ 16'hFFFF);
            check({tag, ".hold_rdy"}, 16'(get_rdy(sel)), 16'h0001);
            check({tag, ".hold_data"}, get_rd(sel), rdata_o);
        end
        drive(sel, 1'b0, we, sz, addr, wd);
        @(negedge clk);
        check({tag, ".rel_rdy_still"}, 16'(get_rdy(sel)), 16'h0001);
        @(negedge clk);
        check({tag, ".rel_rdy_low"}, 16'(get_rdy(sel)), 16'h0000);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        check("reset.rd0", rd0, 16'h0000);
        check("reset.rdy0", 16'(rdy0), 16'h0000);
        check("reset.err0", 16'(err0), 16'h0000);
        check("reset.rd3", rd3, 16'h0000);
        check("reset.rdy3", 16'(rdy3), 16'h0000);
        reset = 1'b0;
        @(negedge clk);

        // 16-bit write then read, zero wait states
        bus_access("w16_0010", 1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1, 0, 1'b0, rdata, berr);
        bus_access("r16_0010", 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 1, 0, 1'b0, rdata, berr);
        check("r16_0010.data", rdata, 16'hBEEF);

        // Byte lanes
        bus_access("w16_0020", 1'b0, 1'b1, 1'b1, 16'h0020, 16'hBEEF, 1, 0, 1'b0, rdata, berr);
        bus_access("w8_0021", 1'b0, 1'b1, 1'b0, 16'h0021, 16'hAB12, 1, 0, 1'b0, rdata, berr);
        bus_access("r16_0020", 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000, 1, 0, 1'b0, rdata, berr);
        check("r16_0020.data", rdata, 16'h12EF);
        bus_access("r8_0020", 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 1, 0, 1'b0, rdata, berr);
        check("r8_0020.data", rdata, 16'h00EF);
        bus_access("r8_0021", 1'b0, 1'b0, 1'b0, 16'h0021, 16'h0000, 1, 0, 1'b0, rdata, berr);
        check("r8_0021.data", rdata, 16'h0012);
        bus_access("r16_0021", 1'b0, 1'b0, 1'b1, 16'h0021, 16'h0000, 1, 0, 1'b0, rdata, berr);
        check("r16_0021.data", rdata, 16'h12EF);

        // Four-phase hold in DONE with changing inputs
        bus_access("hold_0010", 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 1, 10, 1'b0, rdata, berr);
        check("hold_0010.data", rdata, 16'hBEEF);

        // Wait states, top-of-memory boundary, inputs scrambled during WAIT
        bus_access("w16_fffe", 1'b1, 1'b1, 1'b1, 16'hFFFE, 16'h0000, 4, 0, 1'b0, rdata, berr);
        bus_access("w8_ffff", 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h335A, 4, 0, 1'b1, rdata, berr);
        bus_access("r16_fffe", 1'b1, 1'b0, 1'b1, 16'hFFFE, 16'h0000, 4, 0, 1'b1, rdata, berr);
        check("r16_fffe.data", rdata, 16'h5A00);
        bus_access("r8_ffff", 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 4, 0, 1'b1, rdata, berr);
        check("r8_ffff.data", rdata, 16'h005A);
        check("r8_ffff.err", 16'(berr), 16'h0000);

        // Out of range on the 256-word instance
        bus_access("w16_0000", 1'b0, 1'b1, 1'b1, 16'h0000, 16'h1111, 1, 0, 1'b0, rdata, berr);
        bus_access("w16_0200", 1'b0, 1'b1, 1'b1, 16'h0200, 16'h2222, 1, 0, 1'b0, rdata, berr);
        bus_access("r16_0200", 1'b0, 1'b0, 1'b1, 16'h0200, 16'h0000, 1, 0, 1'b0, rdata, berr);
`ifdef SPARK80_MEM_RESP_BOUNDS_CHECK_EN
        check("r16_0200.data", rdata, 16'hFFFF);
        check("r16_0200.err", 16'(berr), 16'h0001);
        check("r16_0200.err_after", 16'(err0), 16'h0000);
`else
        check("r16_0200.data", rdata, 16'h2222);
        check("r16_0200.err", 16'(berr), 16'h0000);
`endif
        bus_access("r16_0000", 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1, 0, 1'b0, rdata, berr);
`ifdef SPARK80_MEM_RESP_BOUNDS_CHECK_EN
        check("r16_0000.data", rdata, 16'h1111);
`else
        check("r16_0000.data", rdata, 16'h2222);
`endif
        check("r16_0000.err", 16'(berr), 16'h0000);

        // Reset in the middle of a wait-state write
        bus_access("w16_0040", 1'b1, 1'b1, 1'b1, 16'h0040, 16'hA5A5, 4, 0, 1'b0, rdata, berr);
        bus_access("r16_0040", 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 4, 0, 1'b0, rdata, berr);
        check("r16_0040.data", rdata, 16'hA5A5);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0040, 16'h1234);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid.rdy3", 16'(rdy3), 16'h0000);
        check("rst_mid.rd3", rd3, 16'h0000);
        check("rst_mid.rd0", rd0, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus_access("r16_0040_post", 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 4, 0, 1'b0, rdata, berr);
        check("r16_0040_post.data", rdata, 16'hA5A5);
        bus_access("r16_0020_post", 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000, 1, 0, 1'b0, rdata, berr);
        check("r16_0020_post.data", rdata, 16'h12EF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spark80_mem_responder.md
# spark80_mem_responder

Synthesizable memory-side responder for the Spark80 CPU data bus. It accepts CPU `req_rdwr` requests, performs 8-bit or 16-bit reads and writes on an internal word-organised RAM with byte lanes, and answers with `data_ready` and read data. It is the target end of the bus the CPU drives, and replaces the simulation-only test memory for FPGA builds.

## Interface
- `ADDR_WIDTH`, 16: byte-address width; RAM holds 2^(ADDR_WIDTH-1) 16-bit words.
- `WAIT_STATES`, 0: extra cycles inserted before each access completes (0..15).
- `DEPTH_WORDS`, 2^(ADDR_WIDTH-1): implemented words; must be ≤ 2^(ADDR_WIDTH-1).

- `clk`  in  1  clock. Everything is on the rising edge. There is one clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_rdwr`  in  1  CPU request, a four-phase level.
- `addr_in`  in  ADDR_WIDTH  byte address.
- `data_acc_sz`  in  1  access size: 0 = 8-bit, 1 = 16-bit (`pkg_cpu` encoding).
- `data_inout_we`  in  1  1 = write, 0 = read.
- `write_data_in`  in  16  write data. 8-bit writes use bits [7:0].
- `read_data_out`  out  16  registered read data. 8-bit reads are zero-extended.
- `data_ready`  out  1  access complete.
- `bus_err`  out  1  address out of range (see Configuration).

## Operation
- **Memory layout:** word index = `addr_in >> 1`. Little-endian byte lanes: an even byte address maps to [7:0], an odd byte address maps to [15:8].
- **16-bit accesses:** `addr_in[0]` is ignored.
- **FSM states:** IDLE, WAIT, DONE.
- **IDLE:**
  - On `req_rdwr`=1, capture `addr_in`, `data_acc_sz`, `data_inout_we` and `write_data_in`.
  - Load the wait counter with `WAIT_STATES`.
  - Go to WAIT if `WAIT_STATES`>0. Otherwise perform the access and go to DONE.
- **WAIT:**
  - Decrement the counter each cycle.
  - When the counter reaches 1, perform the access and go to DONE.
  - Input changes during WAIT are ignored, including `req_rdwr` falling.
- **The access:**
  - A write updates only the addressed lane for 8-bit, or both lanes for 16-bit.
  - A read loads `read_data_out` as `{8'h00, byte}` for 8-bit, or the full word for 16-bit.
  - A write leaves `read_data_out` unchanged.
- **DONE:**
  - `data_ready`=1 and `read_data_out` is held stable.
  - Stay in DONE while `req_rdwr`=1. A new access is never started from DONE.
  - Go to IDLE when `req_rdwr`=0.
- **Reset values:** state=IDLE, `data_ready`=0, `read_data_out`=16'h0000, `bus_err`=0, wait counter=0.
- **RAM under reset:** contents are not cleared.
- **Reset mid-operation:** an access that has not yet been performed is dropped, with no partial write.

## Timing
- **Request-to-ready latency:** request sampled at edge k gives `data_ready` high after edge k+1+`WAIT_STATES`. Read data is valid in that same cycle.
- **Release:** `req_rdwr` sampled low in DONE at edge m gives `data_ready` low after edge m+1. A request is accepted from IDLE no earlier than edge m+1.
- **Minimum bus cycle:** 3 clocks with `WAIT_STATES`=0 (accept, DONE, drop back to IDLE).
- **Write visibility:** a read issued after a write to the same address returns the written data; there is no hazard, because accesses are serialised.
- **Boundary:** the highest byte address (all ones) accesses lane [15:8] of the last word.

## Configuration
- Macro: `SPARK80_MEM_RESP_BOUNDS_CHECK_EN`.
- **Defined:**
  - A word index ≥ `DEPTH_WORDS` completes with normal handshake timing.
  - Writes are suppressed and reads return 16'hFFFF.
  - `bus_err`=1 during DONE and 0 otherwise.
- **Undefined:**
  - The word index wraps modulo `DEPTH_WORDS`.
  - `bus_err` is tied to 0, and no comparator is synthesised.

## Test plan
- **16-bit write then read** (`WAIT_STATES`=0): write 16'hBEEF to 16'h0010, drop the request, then read 16'h0010 as 16-bit. Expect `data_ready` 1 cycle after acceptance and `read_data_out`=16'hBEEF.
- **Byte lanes:** 8-bit write 8'h12 to 16'h0021 over word 16'hBEEF. A 16-bit read of 16'h0020 returns 16'h12EF. An 8-bit read of 16'h0020 returns 16'h00EF.
- **Wait states** (`WAIT_STATES`=3): a read request must raise `data_ready` exactly 4 cycles after acceptance. Toggling `addr_in` during WAIT must not change the result.
- **Four-phase hold:** hold `req_rdwr` high for 10 cycles in DONE. Expect `data_ready` and `read_data_out` stable, no second access, and `data_ready` low 1 cycle after `req_rdwr` falls.
- **Reset mid-WAIT:** assert `reset` asynchronously during a write with `WAIT_STATES`=3. Expect `data_ready`=0 and `read_data_out`=0 immediately, and the target word unchanged on a later read.
- **Out of range** (`DEPTH_WORDS`=256, address 16'h0200):
  - With the macro: a write is ignored, a read returns 16'hFFFF and `bus_err`=1 in DONE.
  - Without the macro: the access aliases word 0.
